// File: rtl/threeway_pkg.sv
// Shared types, constants and round primitives for the 3-Way cipher datapath.
// Word order: word0 = [31:0], word1 = [63:32], word2 = [95:64].
package threeway_pkg;

  typedef logic [31:0] word_t;
  typedef logic [95:0] block_t;

  localparam logic [16:0] ERCON_INIT = 17'h00B0B;
  localparam logic [16:0] DRCON_INIT = 17'h0B1B1;
  localparam logic [16:0] RC_POLY    = 17'h11011;

  // One output word of theta; a is the word's own input, b and c the next two cyclically.
  function automatic word_t theta_word(input word_t a, input word_t b, input word_t c);
    return a ^ (a >> 16) ^ (b << 16) ^ (b >> 16) ^ (c << 16) ^ (b >> 24) ^ (c << 8) ^
           (c >> 8) ^ (a << 24) ^ (c >> 16) ^ (a << 16) ^ (c >> 24) ^ (a << 8);
  endfunction

  function automatic block_t theta(input block_t s);
    return {theta_word(s[95:64], s[31:0],  s[63:32]),
            theta_word(s[63:32], s[95:64], s[31:0]),
            theta_word(s[31:0],  s[63:32], s[95:64])};
  endfunction

  function automatic block_t pi1(input block_t s);
    return {s[94:64], s[95], s[63:32], s[9:0], s[31:10]};
  endfunction

  function automatic block_t pi2(input block_t s);
    return {s[73:64], s[95:74], s[63:32], s[30:0], s[31]};
  endfunction

  function automatic block_t gamma(input block_t s);
    word_t a0, a1, a2;
    a0 = s[31:0];
    a1 = s[63:32];
    a2 = s[95:64];
    return {a2 ^ (a0 | ~a1), a1 ^ (a2 | ~a0), a0 ^ (a1 | ~a2)};
  endfunction

  function automatic word_t rev32(input word_t w);
    word_t r;
    for (int i = 0; i < 32; i++) r[i] = w[31-i];
    return r;
  endfunction

  function automatic block_t mu(input block_t s);
    return {rev32(s[31:0]), rev32(s[63:32]), rev32(s[95:64])};
  endfunction

  // Next round constant; RC_POLY also clears bit 16, so rc never exceeds 16 bits.
  function automatic logic [16:0] rndcon(input logic [16:0] rc);
    logic [16:0] s;
    s = {rc[15:0], 1'b0};
    if (s[16]) s = s ^ RC_POLY;
    return s;
  endfunction

endpackage

// File: rtl/threeway_if.sv
// Block-in / result-out handshake bundle of the 3-Way engine.
interface threeway_if;
  import threeway_pkg::*;

  logic   in_valid;
  logic   in_ready;
  block_t in_block;
  block_t in_key;
  logic   in_decrypt;
  logic   out_valid;
  logic   out_ready;
  block_t out_block;

  modport master (output in_valid, in_block, in_key, in_decrypt, out_ready,
                  input  in_ready, out_valid, out_block);
  modport slave  (input  in_valid, in_block, in_key, in_decrypt, out_ready,
                  output in_ready, out_valid, out_block);
endinterface

// File: rtl/threeway_round.sv
// Combinational round-key/constant add followed by rho = pi2(gamma(pi1(theta(.)))).
module threeway_round
  import threeway_pkg::*;
(
  input  block_t      state_i,
  input  block_t      key_i,
  input  logic [16:0] rc_i,
  output block_t      ka_o,
  output block_t      rho_o
);

  // rc enters word2 zero-extended and word0 shifted up 16 (truncated to 32 bits).
  assign ka_o  = state_i ^ key_i ^ {15'b0, rc_i, 32'b0, rc_i[15:0], 16'b0};
  assign rho_o = pi2(gamma(pi1(theta(ka_o))));

endmodule

// File: rtl/threeway_core.sv
// Iterative 3-Way engine, one rho round per clock. Decryption support is built
// only when THREEWAY_DECRYPT_EN is defined; otherwise in_decrypt is ignored.
module threeway_core #(
  parameter int unsigned NROUNDS = 11
) (
  input logic       clk,
  input logic       rst_n,
  threeway_if.slave bus
);
  import threeway_pkg::*;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam logic [3:0] LAST_RND = 4'(NROUNDS);

  logic [1:0]  fsm_q, fsm_d;
  block_t      state_q, state_d;
  block_t      key_q, key_d;
  logic [16:0] rc_q, rc_d;
  logic [3:0]  cnt_q, cnt_d;

  block_t      ka, rho;
  block_t      load_block, load_key, final_block;
  logic [16:0] load_rc;

  threeway_round u_round (
    .state_i (state_q),
    .key_i   (key_q),
    .rc_i    (rc_q),
    .ka_o    (ka),
    .rho_o   (rho)
  );

`ifdef THREEWAY_DECRYPT_EN
  logic dec_q, dec_d;

  // Decryption runs the same rounds with the inverse key mu(theta(k)) and mu on both ends.
  always_comb begin
    load_block  = bus.in_decrypt ? mu(bus.in_block) : bus.in_block;
    load_key    = bus.in_decrypt ? mu(theta(bus.in_key)) : bus.in_key;
    load_rc     = bus.in_decrypt ? DRCON_INIT : ERCON_INIT;
    final_block = dec_q ? mu(theta(ka)) : theta(ka);
  end

  assign dec_d = (fsm_q == S_IDLE && bus.in_valid) ? bus.in_decrypt : dec_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) dec_q <= 1'b0;
    else        dec_q <= dec_d;
  end
`else
  logic unused_decrypt;
  assign unused_decrypt = bus.in_decrypt;
  assign load_block     = bus.in_block;
  assign load_key       = bus.in_key;
  assign load_rc        = ERCON_INIT;
  assign final_block    = theta(ka);
`endif

  // NOTE: every always_comb output gets its hold value first, so no path can infer a latch.
  always_comb begin
    fsm_d   = fsm_q;
    state_d = state_q;
    key_d   = key_q;
    rc_d    = rc_q;
    cnt_d   = cnt_q;
    case (fsm_q)
      S_IDLE: if (bus.in_valid) begin
        state_d = load_block;
        key_d   = load_key;
        rc_d    = load_rc;
        cnt_d   = 4'd0;
        fsm_d   = S_RUN;
      end
      S_RUN: if (cnt_q == LAST_RND) begin
        state_d = final_block;
        fsm_d   = S_DONE;
      end else begin
        state_d = rho;
        rc_d    = rndcon(rc_q);
        cnt_d   = cnt_q + 4'd1;
      end
      S_DONE: if (bus.out_ready) fsm_d = S_IDLE;
      default: fsm_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all of them update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q   <= S_IDLE;
      state_q <= '0;
      key_q   <= '0;
      rc_q    <= '0;
      cnt_q   <= '0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      key_q   <= key_d;
      rc_q    <= rc_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.in_ready  = (fsm_q == S_IDLE);
  assign bus.out_valid = (fsm_q == S_DONE);
  assign bus.out_block = state_q;

endmodule

// File: tb/tb_threeway_core.sv
// Self-checking bench for threeway_core against a word-array reference model of 3-Way.
module tb_threeway_core;

  localparam int NR = 11;
  localparam int NB = 100;
`ifdef THREEWAY_DECRYPT_EN
  localparam bit DEC_EN = 1'b1;
`else
  localparam bit DEC_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  threeway_if bus ();
  threeway_if bus0 ();

  threeway_core #(.NROUNDS(NR)) dut  (.clk(clk), .rst_n(rst_n), .bus(bus));
  threeway_core #(.NROUNDS(0))  dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));

  int errors = 0;
  int checks = 0;
  logic [95:0] q_exp [$];

  task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] wd(input logic [95:0] x, input int i);
    return x[32*i +: 32];
  endfunction

  function automatic logic [31:0] rotl(input logic [31:0] v, input int n);
    return (v << n) | (v >> (32 - n));
  endfunction

  function automatic logic [95:0] m_theta(input logic [95:0] x);
    logic [95:0] y;
    logic [31:0] a, b, c;
    for (int i = 0; i < 3; i++) begin
      a = wd(x, i);
      b = wd(x, (i + 1) % 3);
      c = wd(x, (i + 2) % 3);
      y[32*i +: 32] = a ^ (a >> 16) ^ (b << 16) ^ (b >> 16) ^ (c << 16) ^ (b >> 24) ^
                      (c << 8) ^ (c >> 8) ^ (a << 24) ^ (c >> 16) ^ (a << 16) ^
                      (c >> 24) ^ (a << 8);
    end
    return y;
  endfunction

  function automatic logic [95:0] m_rho(input logic [95:0] x);
    logic [95:0] y, z;
    y = m_theta(x);
    y[31:0]  = rotl(y[31:0], 22);
    y[95:64] = rotl(y[95:64], 1);
    for (int i = 0; i < 3; i++)
      z[32*i +: 32] = wd(y, i) ^ (wd(y, (i + 1) % 3) | ~wd(y, (i + 2) % 3));
    z[31:0]  = rotl(z[31:0], 1);
    z[95:64] = rotl(z[95:64], 22);
    return z;
  endfunction

  function automatic logic [95:0] m_mu(input logic [95:0] x);
    logic [95:0] y;
    for (int j = 0; j < 96; j++) y[j] = x[95-j];
    return y;
  endfunction

  function automatic logic [95:0] ref_cipher(input logic [95:0] blk, input logic [95:0] key,
                                             input bit dec, input int nr);
    logic [95:0] a, k;
    int rc;
    a  = blk;
    k  = key;
    rc = 'h0B0B;
    if (dec) begin
      a  = m_mu(a);
      k  = m_mu(m_theta(k));
      rc = 'hB1B1;
    end
    for (int r = 0; r <= nr; r++) begin
      a = a ^ k ^ {32'(rc), 32'h0, 32'(rc << 16)};
      if (r < nr) a = m_rho(a);
      else begin
        a = m_theta(a);
        if (dec) a = m_mu(a);
      end
      rc = rc << 1;
      if ((rc & 'h10000) != 0) rc = rc ^ 'h11011;
    end
    return a;
  endfunction

  function automatic logic [95:0] rnd96();
    return {$urandom, $urandom, $urandom};
  endfunction

  // ---------------- drivers ----------------
  task automatic send(input logic [95:0] blk, input logic [95:0] key, input bit dec);
    int w;
    w = 0;
    @(negedge clk);
    while (!bus.in_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    check("send_ready", bus.in_ready, 1);
    bus.in_valid   = 1'b1;
    bus.in_block   = blk;
    bus.in_key     = key;
    bus.in_decrypt = dec;
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  // Called at the first negedge after the accepting edge; k counts negedges from there (1-based).
  task automatic wait_out(output int k);
    k = 1;
    while (!bus.out_valid && k < 100) begin
      @(negedge clk);
      k++;
    end
  endtask

  task automatic finish_out(input string tag);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check({tag, "_valid_drop"}, bus.out_valid, 0);
    check({tag, "_ready_back"}, bus.in_ready, 1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [95:0] ct, exp_v, blk, key, held;
    int k, accepts, outs, cyc, last_acc, in_flight;
    bit dec, bad, rdy_bad, gap_bad, pending_new;

    bus.in_valid  = 0; bus.in_block  = '0; bus.in_key  = '0; bus.in_decrypt  = 0; bus.out_ready  = 0;
    bus0.in_valid = 0; bus0.in_block = '0; bus0.in_key = '0; bus0.in_decrypt = 0; bus0.out_ready = 0;
    rst_n = 1'b0;
    #2;
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_block", bus.out_block, '0);
    check("rst0_in_ready", bus0.in_ready, 1);
    check("rst0_out_valid", bus0.out_valid, 0);
    check("rst0_out_block", bus0.out_block, '0);
    @(negedge clk);
    rst_n = 1'b1;

    // Encrypt {1,1,1} with key 0; result visible 13 cycles after the accept cycle.
    ct = ref_cipher({32'h1, 32'h1, 32'h1}, '0, 1'b0, NR);
    send({32'h1, 32'h1, 32'h1}, '0, 1'b0);
    wait_out(k);
    check("enc111_latency", k, NR + 2);
    check("enc111_value", bus.out_block, ct);

    // Stall in DONE for 20 cycles while a new block is offered.
    held = ct;
    bad  = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_block = rnd96();
    bus.in_key   = rnd96();
    repeat (20) begin
      @(negedge clk);
      if (bus.out_valid !== 1'b1 || bus.out_block !== held || bus.in_ready !== 1'b0) bad = 1'b1;
    end
    bus.in_valid = 1'b0;
    check("done_hold_stable", bad, 0);
    finish_out("enc111");

    // Decrypt of the ciphertext (treated as encryption when decryption is not built).
    exp_v = DEC_EN ? {32'h1, 32'h1, 32'h1} : ref_cipher(ct, '0, 1'b0, NR);
    send(ct, '0, 1'b1);
    wait_out(k);
    check("dec_latency", k, NR + 2);
    check("dec_value", bus.out_block, exp_v);
    finish_out("dec");

    // Back-to-back random blocks with a scoreboard; in_valid held high, out_ready high.
    accepts = 0; outs = 0; cyc = 0; last_acc = -1;
    rdy_bad = 0; gap_bad = 0; pending_new = 0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    blk = rnd96(); key = rnd96(); dec = 1'($urandom_range(0, 1));
    bus.in_block = blk; bus.in_key = key; bus.in_decrypt = dec; bus.in_valid = 1'b1;
    while (outs < NB && cyc < 4000) begin
      if (pending_new) begin
        pending_new = 0;
        if (accepts < NB) begin
          blk = rnd96(); key = rnd96(); dec = 1'($urandom_range(0, 1));
          bus.in_block = blk; bus.in_key = key; bus.in_decrypt = dec;
        end else bus.in_valid = 1'b0;
      end
      in_flight = accepts - outs;
      if (bus.in_ready !== (in_flight == 0)) rdy_bad = 1'b1;
      if (bus.out_valid) begin
        if (q_exp.size() == 0) check("b2b_extra_out", bus.out_valid, 0);
        else check("b2b_result", bus.out_block, q_exp.pop_front());
        outs++;
      end
      if (bus.in_ready && bus.in_valid) begin
        q_exp.push_back(ref_cipher(blk, key, dec && DEC_EN, NR));
        accepts++;
        if (last_acc >= 0 && cyc - last_acc != NR + 3) gap_bad = 1'b1;
        last_acc    = cyc;
        pending_new = 1'b1;
      end
      @(negedge clk);
      cyc++;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    check("b2b_accepts", accepts, NB);
    check("b2b_outputs", outs, NB);
    check("b2b_interval", gap_bad, 0);
    check("b2b_ready_busy", rdy_bad, 0);

    // Reset in the middle of RUN.
    send(rnd96(), rnd96(), 1'b0);
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_run_valid", bus.out_valid, 0);
    check("rst_run_ready", bus.in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset while holding a result in DONE: out_valid must fall before any clock edge.
    send(rnd96(), rnd96(), 1'b0);
    wait_out(k);
    check("pre_rst_done_valid", bus.out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_done_valid", bus.out_valid, 0);
    check("rst_done_ready", bus.in_ready, 1);
    check("rst_done_block", bus.out_block, '0);
    @(negedge clk);
    rst_n = 1'b1;

    // The next block after reset completes correctly.
    blk = rnd96(); key = rnd96();
    send(blk, key, 1'b0);
    wait_out(k);
    check("post_rst_latency", k, NR + 2);
    check("post_rst_value", bus.out_block, ref_cipher(blk, key, 1'b0, NR));
    finish_out("post_rst");

    // NROUNDS=0 instance: final transform only, result one cycle after RUN entry.
    @(negedge clk);
    check("nr0_ready", bus0.in_ready, 1);
    bus0.in_valid = 1'b1;
    @(negedge clk);
    bus0.in_valid = 1'b0;
    k = 1;
    while (!bus0.out_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("nr0_latency", k, 2);
    check("nr0_value", bus0.out_block, m_theta({32'h0000_0B0B, 32'h0, 32'h0B0B_0000}));
    bus0.out_ready = 1'b1;
    @(negedge clk);
    bus0.out_ready = 1'b0;
    check("nr0_valid_drop", bus0.out_valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
